// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
//   NUM_SRC     : number of interrupt sources (fixed at 4)
//   ID_W        : width of the presented source index
//   irq_state_t : handshake FSM states
//   prio_sel    : highest set index of a source vector (index NUM_SRC-1 wins)
package irq_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

  // Ascending scan so the last hit, i.e. the highest index, is returned.
  function automatic logic [ID_W-1:0] prio_sel(input logic [NUM_SRC-1:0] vec);
    logic [ID_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec[i]) sel = ID_W'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_pending_controller_if.sv
// Interrupt presentation handshake between the controller and its consumer.
//   irq_valid : an id is being presented
//   irq_id    : index of the presented source
//   irq_ack   : consumer accepts irq_id
// Handshake: a transfer happens on a rising clk edge where irq_valid && irq_ack.
// Once irq_valid rises, irq_id is held unchanged and irq_valid stays high until
// that transfer; irq_ack while irq_valid is low has no effect.
interface irq_pending_controller_if;

  logic                     irq_valid;
  logic [irq_pkg::ID_W-1:0] irq_id;
  logic                     irq_ack;

  modport master (output irq_valid, output irq_id, input irq_ack);
  modport slave  (input irq_valid, input irq_id, output irq_ack);

endinterface

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the raw source levels.
//   clk, rst : clock, synchronous active-high reset
//   src_i    : source levels, already synchronous to clk
//   rise_o   : one-cycle pulse per bit where src_i goes 0 -> 1
// The history register resets to all-ones so a source already high when
// reset releases does not register as a new edge.
module irq_edge_detect
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] rise_o
);

  logic [NUM_SRC-1:0] src_q;

  always_ff @(posedge clk) begin
    if (rst) src_q <= '1;
    else     src_q <= src_i;
  end

  assign rise_o = src_i & ~src_q;

endmodule

// File: rtl/irq_pending_controller.sv
// Four-source interrupt collector.
//   clk, rst    : clock, synchronous active-high reset
//   src_i       : raw source levels; rising edges set sticky pending bits
//   mask_i      : 1 = source may be selected (pending is captured regardless)
//   ovf_clr_i   : write-1-to-clear for overflow bits
//   pending_o   : pending register, unmasked
//   overflow_o  : sticky, an edge arrived while that bit was already pending
//   state_o     : current handshake FSM state, for observation
//   irq_if      : master side of the valid/ack presentation handshake
module irq_pending_controller
  import irq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_i,
  input  logic [NUM_SRC-1:0]         mask_i,
  input  logic [NUM_SRC-1:0]         ovf_clr_i,
  output logic [NUM_SRC-1:0]         pending_o,
  output logic [NUM_SRC-1:0]         overflow_o,
  output irq_state_t                 state_o,
  irq_pending_controller_if.master   irq_if
);

  irq_state_t         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] served;
  logic [NUM_SRC-1:0] eligible;
  logic               ack_fire;

  irq_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .src_i  (src_i),
    .rise_o (rise)
  );

  assign ack_fire = (state_q == PRESENT) && irq_if.irq_ack;
  // One-hot of the bit being serviced this cycle, zero when no transfer.
  assign served   = ack_fire ? (NUM_SRC'(1) << id_q) : '0;
  assign eligible = pending_q & mask_i;

  // A fresh edge beats the service clear, so a re-raise during ack is kept.
  assign pending_d  = rise | (pending_q & ~served);
  // A new loss beats a simultaneous clear request.
  assign overflow_d = (overflow_q & ~ovf_clr_i) | (rise & pending_q & ~served);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic; the id is only captured when leaving IDLE so it cannot
  // move while presented.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = PRESENT;
          id_d    = prio_sel(eligible);
        end
      end
      PRESENT: begin
        if (ack_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    irq_if.irq_valid = (state_q == PRESENT);
    irq_if.irq_id    = id_q;
    pending_o        = pending_q;
    overflow_o       = overflow_q;
    state_o          = state_q;
  end

endmodule

// File: tb/tb_irq_pending_controller.sv
module tb_irq_pending_controller;
  import irq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] src, mask, ovf_clr;
  logic [3:0] pending, overflow;
  irq_state_t state;

  irq_pending_controller_if bus ();

  irq_pending_controller dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src),
    .mask_i     (mask),
    .ovf_clr_i  (ovf_clr),
    .pending_o  (pending),
    .overflow_o (overflow),
    .state_o    (state),
    .irq_if     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Tracks per-source booleans and the presented interrupt as integers.
  bit m_prev[4];
  bit m_pend[4];
  bit m_ovf[4];
  bit m_valid;
  int m_id;

  function automatic logic [3:0] pack(input bit a[4]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = a[i];
    return v;
  endfunction

  // Advances the model by one clock using the inputs currently driven,
  // then lets the DUT take the same edge and returns at the falling edge.
  task automatic step();
    bit n_pend[4], n_ovf[4], n_valid;
    int n_id;
    bit fire;
    n_id = m_id;
    n_valid = m_valid;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        n_pend[i] = 0; n_ovf[i] = 0;
      end
      n_valid = 0; n_id = 0;
    end else begin
      fire = m_valid && bus.irq_ack;
      for (int i = 0; i < 4; i++) begin
        bit rose, srv;
        rose = src[i] && !m_prev[i];
        srv  = fire && (m_id == i);
        if (rose)     n_pend[i] = 1;
        else if (srv) n_pend[i] = 0;
        else          n_pend[i] = m_pend[i];
        if (rose && m_pend[i] && !srv) n_ovf[i] = 1;
        else if (ovf_clr[i])           n_ovf[i] = 0;
        else                           n_ovf[i] = m_ovf[i];
      end
      if (m_valid) begin
        if (fire) n_valid = 0;
      end else begin
        for (int i = 3; i >= 0; i--) begin
          if (m_pend[i] && mask[i]) begin
            n_valid = 1; n_id = i; break;
          end
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) m_prev[i] = rst ? 1'b1 : src[i];
    m_pend = n_pend; m_ovf = n_ovf; m_valid = n_valid; m_id = n_id;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; src = 0; mask = 4'hF; ovf_clr = 0; bus.irq_ack = 0;
    step(); step();
    rst = 0;
    step();
    n_checks++;
    if (pending !== 4'b0 || overflow !== 4'b0 || bus.irq_valid !== 1'b0 || bus.irq_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: pend=%b ovf=%b valid=%b id=%0d want 0000 0000 0 0", pending, overflow, bus.irq_valid, bus.irq_id);
    end
  endtask

  task automatic test_edge_to_grant();
    src = 4'b0001; step();
    n_checks++;
    if (pending !== 4'b0001 || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL e2g_pend: pend=%b valid=%b want 0001 0", pending, bus.irq_valid);
    end
    src = 0; step();
    n_checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0) begin
      n_fail++; $display("FAIL e2g_grant: valid=%b id=%0d want 1 0", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    n_checks++;
    if (pending !== 4'b0 || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL e2g_ack: pend=%b valid=%b want 0000 0", pending, bus.irq_valid);
    end
  endtask

  task automatic test_priority();
    src = 4'b0101; step(); src = 0; step();
    n_checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd2) begin
      n_fail++; $display("FAIL prio_first: valid=%b id=%0d want 1 2", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    n_checks++;
    if (bus.irq_valid !== 1'b0 || pending !== 4'b0001) begin
      n_fail++; $display("FAIL prio_bubble: valid=%b pend=%b want 0 0001", bus.irq_valid, pending);
    end
    step();
    n_checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0) begin
      n_fail++; $display("FAIL prio_second: valid=%b id=%0d want 1 0", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    n_checks++;
    if (bus.irq_valid !== 1'b0 || pending !== 4'b0) begin
      n_fail++; $display("FAIL prio_done: valid=%b pend=%b want 0 0000", bus.irq_valid, pending);
    end
  endtask

  task automatic test_mask();
    mask = 4'b0111; src = 4'b1000; step(); src = 0; step(); step();
    n_checks++;
    if (pending !== 4'b1000 || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL mask_hold: pend=%b valid=%b want 1000 0", pending, bus.irq_valid);
    end
    mask = 4'hF; step();
    n_checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3) begin
      n_fail++; $display("FAIL mask_release: valid=%b id=%0d want 1 3", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
  endtask

  task automatic test_stability();
    src = 4'b0010; step(); src = 0; step();
    src = 4'b1000; mask = 4'b1101; step(); src = 0; step();
    n_checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd1 || pending !== 4'b1010) begin
      n_fail++; $display("FAIL stable_hold: valid=%b id=%0d pend=%b want 1 1 1010", bus.irq_valid, bus.irq_id, pending);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0; mask = 4'hF; step();
    n_checks++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3) begin
      n_fail++; $display("FAIL stable_next: valid=%b id=%0d want 1 3", bus.irq_valid, bus.irq_id);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
  endtask

  task automatic test_overflow_race();
    src = 4'b0100; step(); src = 0; step();
    src = 4'b0100; step(); src = 0; step();
    n_checks++;
    if (overflow !== 4'b0100 || bus.irq_id !== 2'd2) begin
      n_fail++; $display("FAIL ovf_set: ovf=%b id=%0d want 0100 2", overflow, bus.irq_id);
    end
    src = 4'b0100; bus.irq_ack = 1; step(); bus.irq_ack = 0; src = 0;
    n_checks++;
    if (pending !== 4'b0100 || overflow !== 4'b0100 || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_race: pend=%b ovf=%b valid=%b want 0100 0100 0", pending, overflow, bus.irq_valid);
    end
    ovf_clr = 4'b0100; step(); ovf_clr = 0;
    n_checks++;
    if (overflow !== 4'b0000) begin
      n_fail++; $display("FAIL ovf_clr: ovf=%b want 0000", overflow);
    end
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
  endtask

  task automatic test_reset_cases();
    rst = 1; src = 4'hF; step(); step(); rst = 0; step(); step();
    n_checks++;
    if (pending !== 4'b0 || bus.irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_high_src: pend=%b valid=%b want 0000 0", pending, bus.irq_valid);
    end
    src = 0; step(); src = 4'b0001; step(); src = 0; step();
    n_checks++;
    if (bus.irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_present: valid=%b want 1", bus.irq_valid);
    end
    rst = 1; step(); rst = 0;
    n_checks++;
    if (bus.irq_valid !== 1'b0 || pending !== 4'b0 || state !== IDLE) begin
      n_fail++; $display("FAIL rst_in_present: valid=%b pend=%b want 0 0000", bus.irq_valid, pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      src         = 4'($urandom_range(0, 15));
      mask        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      bus.irq_ack = 1'($urandom_range(0, 1));
      ovf_clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step();
      n_checks++;
      if (pending !== pack(m_pend) || overflow !== pack(m_ovf) ||
          bus.irq_valid !== m_valid || (m_valid && bus.irq_id !== 2'(m_id))) begin
        n_fail++;
        $display("FAIL random cyc %0d: pend=%b ovf=%b valid=%b id=%0d want %b %b %b %0d",
                 c, pending, overflow, bus.irq_valid, bus.irq_id,
                 pack(m_pend), pack(m_ovf), m_valid, m_id);
      end
    end
    src = 0; mask = 4'hF; bus.irq_ack = 0; ovf_clr = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_edge_to_grant();
    test_priority();
    test_mask();
    test_stability();
    test_overflow_race();
    test_reset_cases();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
